// File: rtl/dram_resp.sv
// Data-memory responder: word-addressed RAM behind a one-entry write buffer,
// with store-to-load forwarding and a registered valid/ready response.
module dram_resp #(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned LANES  = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic [3:0]       strb;
    } wb_entry_t;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic             wb_load;
    logic             rd_en;

    logic             wb_v;
    wb_entry_t        wb;

    logic [31:0]      rd_q;
    logic [31:0]      fwd_data;
    logic [3:0]       fwd_strb;
    logic             resp_load;

    // Byte-offset bits are ignored; the request is word-aligned by construction.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    // Request decode
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[IDX_W+1:2];
    assign req_err   = |req_addr[31:IDX_W+2];
    assign wb_load   = accept && req_we && !req_err && (req_wstrb != 4'b0000);
    assign rd_en     = accept && !req_we && !req_err;

    // Array: lane-masked drain of the write buffer, read-first synchronous read.
    // Gated by rst so a store pending at reset never lands.
    always_ff @(posedge clk) begin
        if (!rst && wb_v) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wb.strb[i]) begin
                    mem[wb.idx][8*i +: 8] <= wb.data[8*i +: 8];
                end
            end
        end
        if (!rst && rd_en) begin
            rd_q <= mem[req_idx];
        end
    end

    // Write buffer and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v       <= 1'b0;
            wb         <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_load  <= 1'b0;
            fwd_strb   <= 4'b0000;
            fwd_data   <= 32'h0;
        end else begin
            wb_v <= wb_load;
            if (wb_load) begin
                wb.idx  <= req_idx;
                wb.data <= req_wdata;
                wb.strb <= req_wstrb;
            end

            if (accept) begin
                resp_valid <= 1'b1;
                resp_err   <= req_err;
                resp_load  <= rd_en;
                fwd_strb   <= (rd_en && wb_v && (wb.idx == req_idx)) ? wb.strb : 4'b0000;
                fwd_data   <= wb.data;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Merge forwarded lanes over the array word; stores and errors return zero.
    always_comb begin
        resp_rdata = 32'h0;
        if (resp_load) begin
            for (int i = 0; i < int'(LANES); i++) begin
                resp_rdata[8*i +: 8] = fwd_strb[i] ? fwd_data[8*i +: 8] : rd_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dram_resp.sv
// Directed self-checking bench for dram_resp.
module tb_dram_resp;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total;
    int bad;

    dram_resp #(.DEPTH_WORDS(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request presented for exactly one edge; resp_ready is assumed high.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_req_ready",  32'(req_ready),  32'd1);
        chk("reset_rdata",      resp_rdata,      32'h0);
        chk("reset_err",        32'(resp_err),   32'd0);
        rst = 1'b0;
        idle();

        // 1. store then load, forwarded and via array
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("sw_valid",  32'(resp_valid), 32'd1);
        chk("sw_rdata",  resp_rdata,      32'h0);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        chk("fwd_valid", 32'(resp_valid), 32'd1);
        chk("fwd_rdata", resp_rdata,      32'hDEADBEEF);
        idle();
        chk("resp_clears", 32'(resp_valid), 32'd0);
        issue(1'b1, 32'h10, 32'h12345678, 4'hF);
        idle();
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        chk("array_rdata", resp_rdata, 32'h12345678);
        idle();

        // 2. partial strobes back-to-back
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        idle();
        issue(1'b1, 32'h20, 32'h0000AA00, 4'h2);
        issue(1'b1, 32'h20, 32'hBBCC0000, 4'hC);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        chk("partial_fwd", resp_rdata, 32'hBBCCAA44);
        idle();
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        chk("partial_array", resp_rdata, 32'hBBCCAA44);
        idle();

        // 3. backpressure with a held store request
        issue(1'b1, 32'h30, 32'h0BADF00D, 4'hF);
        idle();
        resp_ready = 1'b0;
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h34;
        req_wdata = 32'h00000077;
        req_wstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            chk("stall_req_ready",  32'(req_ready),  32'd0);
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_rdata",      resp_rdata,      32'h0BADF00D);
            idle();
        end
        resp_ready = 1'b1;
        idle();
        req_valid = 1'b0;
        chk("unstall_valid", 32'(resp_valid), 32'd1);
        chk("unstall_rdata", resp_rdata,      32'h0);
        issue(1'b0, 32'h34, 32'h0, 4'h0);
        chk("held_store_landed", resp_rdata, 32'h00000077);
        idle();

        // 4. out of range
        issue(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        idle();
        issue(1'b1, 32'h00004000, 32'hFFFFFFFF, 4'hF);
        chk("oor_sw_err",   32'(resp_err), 32'd1);
        chk("oor_sw_rdata", resp_rdata,    32'h0);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        chk("oor_no_alias", resp_rdata,    32'hA5A5A5A5);
        chk("inrange_err",  32'(resp_err), 32'd0);
        issue(1'b0, 32'h80000000, 32'h0, 4'h0);
        chk("oor_lw_err",   32'(resp_err), 32'd1);
        chk("oor_lw_rdata", resp_rdata,    32'h0);
        idle();

        // 5. reset with a store still buffered
        issue(1'b1, 32'h8, 32'h0, 4'hF);
        idle();
        issue(1'b1, 32'h8, 32'h00000055, 4'hF);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata",      resp_rdata,      32'h0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        chk("rst_discard", resp_rdata, 32'h0);
        idle();

        // 6. zero-strobe store
        issue(1'b1, 32'h4, 32'h01020304, 4'hF);
        idle();
        issue(1'b1, 32'h4, 32'hFFFFFFFF, 4'h0);
        chk("zstrb_valid", 32'(resp_valid), 32'd1);
        chk("zstrb_err",   32'(resp_err),   32'd0);
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("zstrb_fwd",   resp_rdata, 32'h01020304);
        idle();
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        chk("zstrb_array", resp_rdata, 32'h01020304);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
